// File: rtl/window_stream_gen.sv
// Streaming KxK sliding-window generator.
// Takes a raster-order pixel stream over valid/ready, keeps K-1 previous image
// lines in line buffers and a KxK window shift register, and emits every
// complete window (subject to STRIDE) one cycle after its bottom-right pixel
// is accepted, together with the window's top-left image coordinates.
// The output stage is a single register slice, so a pixel can be accepted in
// the same cycle the previous window is handed off.

module window_stream_gen #(
    parameter int IMG_W     = 7,
    parameter int IMG_H     = 7,
    parameter int K         = 3,
    parameter int WIDTH_BIT = 8,
    parameter int STRIDE    = 1
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH_BIT-1:0]         in_pixel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*K*WIDTH_BIT-1:0]     out_window,
    output logic [$clog2(IMG_H)-1:0]     out_row,
    output logic [$clog2(IMG_W)-1:0]     out_col,
    output logic                         out_last
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    // Bottom-right pixel position of the last window emitted in a frame.
    localparam int LAST_ROW = (K - 1) + ((IMG_H - K) / STRIDE) * STRIDE;
    localparam int LAST_COL = (K - 1) + ((IMG_W - K) / STRIDE) * STRIDE;

    // FILL: the first K-1 rows of a frame, only priming the line buffers.
    // RUN : rows K-1 and below, where the window register is live.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Control and output registers.
    state_t                      state_q;
    logic [RW-1:0]               row_q;
    logic [CW-1:0]               col_q;
    logic                        out_valid_q;
    logic                        out_last_q;
    logic [RW-1:0]               out_row_q;
    logic [CW-1:0]               out_col_q;
    logic [K*K*WIDTH_BIT-1:0]    out_window_q;

    // Line buffers: lb_q[0] holds the oldest line, lb_q[K-2] the line just above
    // the current one. All K-1 lines share the column pointer col_q.
    logic [WIDTH_BIT-1:0]        lb_q [K-1][IMG_W];

    // Window shift register, win_q[row][col], column K-1 is the newest.
    logic [WIDTH_BIT-1:0]        win_q [K][K];
    logic [WIDTH_BIT-1:0]        win_d [K][K];
    logic [WIDTH_BIT-1:0]        new_col [K];
    logic [K*K*WIDTH_BIT-1:0]    win_flat;

    // Handshake and position decode.
    logic                        accept;
    logic                        xfer;
    logic                        col_wrap;
    logic                        row_wrap;
    logic [RW-1:0]               row_off;
    logic [CW-1:0]               col_off;
    logic                        row_aligned;
    logic                        col_aligned;
    logic                        col_ready;
    logic                        emit;
    logic                        emit_last;

    // One-deep output slice: free when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    assign col_wrap = (col_q == CW'(IMG_W - 1));
    assign row_wrap = (row_q == RW'(IMG_H - 1));

    // Candidate window origin for the pixel at (row_q, col_q). Only meaningful
    // once row_q >= K-1 (guaranteed in RUN) and col_q >= K-1 (col_ready).
    assign row_off     = row_q - RW'(K - 1);
    assign col_off     = col_q - CW'(K - 1);
    assign row_aligned = ((32'(row_off) % 32'(STRIDE)) == 32'd0);
    assign col_aligned = ((32'(col_off) % 32'(STRIDE)) == 32'd0);

    // The column gate also flushes stale columns left over from the previous
    // row: after a row wrap the window needs K fresh shifts before it is whole.
    assign col_ready = (col_q >= CW'(K - 1));

    assign emit      = accept && (state_q == RUN) && col_ready && row_aligned && col_aligned;
    assign emit_last = (row_q == RW'(LAST_ROW)) && (col_q == CW'(LAST_COL));

    // Build the incoming window column and the shifted window it produces.
    always_comb begin
        // NOTE: every combinational output gets a default before any loop or
        // branch, so no path leaves it unassigned and no latch is inferred.
        new_col  = '{default: '0};
        win_d    = win_q;
        win_flat = '0;

        for (int k = 0; k < K - 1; k++) begin
            new_col[k] = lb_q[k][col_q];
        end
        new_col[K-1] = in_pixel;

        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][K-1] = new_col[i];
        end

        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_flat[(i*K+j)*WIDTH_BIT +: WIDTH_BIT] = win_d[i][j];
            end
        end
    end

    // Line buffers: on every accept, age the current column by one line and
    // store the new pixel as the most recent line.
    // NOTE: storage arrays carry no reset; every entry is rewritten during the
    // FILL rows before it is ever read, so a reset would only cost area.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int k = 0; k < K - 2; k++) begin
                lb_q[k][col_q] <= lb_q[k+1][col_q];
            end
            lb_q[K-2][col_q] <= in_pixel;
        end
    end

    // Window shift register: advances one column per accepted pixel in RUN.
    always_ff @(posedge clock) begin
        if (accept && (state_q == RUN)) begin
            win_q <= win_d;
        end
    end

    // Control FSM, raster counters and the registered output slice.
    always_ff @(posedge clock or negedge nreset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!nreset) begin
            state_q      <= FILL;
            row_q        <= '0;
            col_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_window_q <= '0;
        end else begin
            if (accept) begin
                if (col_wrap) begin
                    col_q <= '0;
                    row_q <= row_wrap ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end

                unique case (state_q)
                    FILL: if (col_wrap && (row_q == RW'(K - 2))) state_q <= RUN;
                    RUN:  if (col_wrap && row_wrap)              state_q <= FILL;
                    default:                                     state_q <= FILL;
                endcase
            end

            if (emit) begin
                out_valid_q  <= 1'b1;
                out_last_q   <= emit_last;
                out_row_q    <= row_off;
                out_col_q    <= col_off;
                out_window_q <= win_flat;
            end else if (xfer) begin
                out_valid_q  <= 1'b0;
                out_last_q   <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_window = out_window_q;

endmodule

// File: tb/tb_window_stream_gen.sv
// Bench for window_stream_gen: two instances (STRIDE=1 and STRIDE=2) see the
// same accepted pixel stream. A frame-level model tracks the image and the
// expected output slice of each instance and is compared every cycle;
// literal expectations pin the first/last windows of each scenario.

module tb_window_stream_gen;

    localparam int W    = 7;
    localparam int H    = 7;
    localparam int K    = 3;
    localparam int WB   = 8;
    localparam int WINW = K * K * WB;

    typedef struct {
        int              row;
        int              col;
        logic [WINW-1:0] win;
        bit              last;
    } obs_t;

    logic            clock = 1'b0;
    logic            nreset = 1'b0;
    logic            in_valid = 1'b0;
    logic [WB-1:0]   in_pixel = '0;
    logic            out_ready = 1'b1;
    logic            out_ready2 = 1'b1;
    logic            in_valid2;

    logic            in_ready1, out_valid1, out_last1;
    logic [WINW-1:0] out_window1;
    logic [2:0]      out_row1, out_col1;
    logic            in_ready2, out_valid2, out_last2;
    logic [WINW-1:0] out_window2;
    logic [2:0]      out_row2, out_col2;

    // The stride-2 instance never stalls, so it accepts exactly what the
    // stride-1 instance accepts.
    assign in_valid2 = in_valid && in_ready1;

    window_stream_gen #(.IMG_W(W), .IMG_H(H), .K(K), .WIDTH_BIT(WB), .STRIDE(1)) dut1 (
        .clock(clock), .nreset(nreset),
        .in_valid(in_valid), .in_ready(in_ready1), .in_pixel(in_pixel),
        .out_valid(out_valid1), .out_ready(out_ready), .out_window(out_window1),
        .out_row(out_row1), .out_col(out_col1), .out_last(out_last1)
    );

    window_stream_gen #(.IMG_W(W), .IMG_H(H), .K(K), .WIDTH_BIT(WB), .STRIDE(2)) dut2 (
        .clock(clock), .nreset(nreset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_pixel(in_pixel),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_window(out_window2),
        .out_row(out_row2), .out_col(out_col2), .out_last(out_last2)
    );

    initial forever #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [WB-1:0]   img [H][W];
    int              mr = 0, mc = 0;
    bit              ev    [2] = '{0, 0};
    int              erow  [2];
    int              ecol  [2];
    bit              elast [2];
    logic [WINW-1:0] ewin  [2];
    int              strd  [2] = '{1, 2};

    obs_t obs1[$];
    obs_t obs2[$];
    obs_t ref1[$];

    function automatic bit emits(int r, int c, int s);
        return (r >= K - 1) && (c >= K - 1) && (((r - K + 1) % s) == 0) && (((c - K + 1) % s) == 0);
    endfunction

    function automatic int last_pos(int n, int s);
        return (K - 1) + ((n - K) / s) * s;
    endfunction

    function automatic logic [WINW-1:0] win_of(int r0, int c0);
        logic [WINW-1:0] w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i*K+j)*WB +: WB] = img[r0+i][c0+j];
        return w;
    endfunction

    // Compare process: check outputs against the model, log transfers, then
    // advance the model by what happens at the coming rising edge.
    always @(negedge clock) begin
        if (!nreset) begin
            mr = 0; mc = 0; ev[0] = 0; ev[1] = 0;
            check("rst_out_valid1", out_valid1, 0);
            check("rst_out_valid2", out_valid2, 0);
            check("rst_in_ready1", in_ready1, 1);
            check("rst_out_last1", out_last1, 0);
            check("rst_out_row1", out_row1, 0);
            check("rst_out_col1", out_col1, 0);
            check("rst_out_window1", out_window1, 0);
        end else begin
            bit acc;
            bit x [2];
            check("in_ready1", in_ready1, (!ev[0] || out_ready));
            check("in_ready2", in_ready2, 1);
            check("out_valid1", out_valid1, ev[0]);
            check("out_valid2", out_valid2, ev[1]);
            if (ev[0]) begin
                check("out_row1", out_row1, erow[0]);
                check("out_col1", out_col1, ecol[0]);
                check("out_window1", out_window1, ewin[0]);
                check("out_last1", out_last1, elast[0]);
            end
            if (ev[1]) begin
                check("out_row2", out_row2, erow[1]);
                check("out_col2", out_col2, ecol[1]);
                check("out_window2", out_window2, ewin[1]);
                check("out_last2", out_last2, elast[1]);
            end
            if (out_valid1 && out_ready) obs1.push_back('{int'(out_row1), int'(out_col1), out_window1, out_last1});
            if (out_valid2) obs2.push_back('{int'(out_row2), int'(out_col2), out_window2, out_last2});

            acc  = in_valid && (!ev[0] || out_ready);
            x[0] = ev[0] && out_ready;
            x[1] = ev[1];
            if (acc) img[mr][mc] = in_pixel;
            for (int d = 0; d < 2; d++) begin
                if (acc && emits(mr, mc, strd[d])) begin
                    ev[d]    = 1;
                    erow[d]  = mr - K + 1;
                    ecol[d]  = mc - K + 1;
                    ewin[d]  = win_of(erow[d], ecol[d]);
                    elast[d] = (mr == last_pos(H, strd[d])) && (mc == last_pos(W, strd[d]));
                end else if (x[d]) begin
                    ev[d] = 0;
                end
            end
            if (acc) begin
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [WB-1:0] p, input int gap_pct);
        bit acc = 0;
        int n = 0;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_pixel = p;
        do begin
            @(negedge clock);
            acc = in_ready1;
            @(posedge clock); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int gap_pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(WB'(base + W * r + c), gap_pct);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
    endtask

    task automatic stall();
        int n = 0;
        logic [WINW-1:0] hw;
        logic [2:0] hr, hc;
        do begin @(posedge clock); #1; n++; end while (!out_valid1 && n < 200);
        check("s3_found_valid", out_valid1, 1);
        out_ready = 1'b0;
        hw = out_window1; hr = out_row1; hc = out_col1;
        repeat (5) begin
            @(negedge clock);
            check("s3_in_ready_low", in_ready1, 0);
            check("s3_hold_valid", out_valid1, 1);
            check("s3_hold_window", out_window1, hw);
            check("s3_hold_row", out_row1, hr);
            check("s3_hold_col", out_col1, hc);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
    endtask

    int first_exp [9] = '{0, 1, 2, 7, 8, 9, 14, 15, 16};

    initial begin
        obs_t o;
        int nl;

        repeat (2) begin @(posedge clock); #1; end
        nreset = 1'b1;

        // Scenario 1 + 2: full frame, both strides in parallel.
        obs1.delete(); obs2.delete();
        send_frame(0, 0);
        drain();
        check("s1_count", obs1.size(), 25);
        if (obs1.size() == 25) begin
            o = obs1[0];
            check("s1_first_row", o.row, 0);
            check("s1_first_col", o.col, 0);
            for (int e = 0; e < 9; e++)
                check($sformatf("s1_first_e%0d", e), o.win[e*WB +: WB], first_exp[e]);
            o = obs1[24];
            check("s1_last_row", o.row, 4);
            check("s1_last_col", o.col, 4);
            check("s1_last_flag", o.last, 1);
            check("s1_last_e22", o.win[8*WB +: WB], 48);
        end
        nl = 0;
        foreach (obs1[k]) if (obs1[k].last) nl++;
        check("s1_last_count", nl, 1);
        ref1 = obs1;

        check("s2_count", obs2.size(), 9);
        foreach (obs2[k]) begin
            check($sformatf("s2_row%0d", k), obs2[k].row, 2 * (k / 3));
            check($sformatf("s2_col%0d", k), obs2[k].col, 2 * (k % 3));
            check($sformatf("s2_last%0d", k), obs2[k].last, (k == 8));
        end
        if (obs2.size() == 9) begin
            o = obs2[5];
            check("s2_w24_e00", o.win[0 +: WB], 18);
        end

        // Scenario 3: five-cycle output stall mid-frame.
        obs1.delete(); obs2.delete();
        fork
            send_frame(0, 0);
            stall();
        join
        drain();
        check("s3_count", obs1.size(), 25);
        foreach (obs1[k]) begin
            check($sformatf("s3_row%0d", k), obs1[k].row, k / 5);
            check($sformatf("s3_col%0d", k), obs1[k].col, k % 5);
            if (k < ref1.size()) check($sformatf("s3_win%0d", k), obs1[k].win, ref1[k].win);
        end

        // Scenario 4: random 50% input gaps.
        obs1.delete(); obs2.delete();
        send_frame(0, 50);
        drain();
        check("s4_count", obs1.size(), 25);
        foreach (obs1[k]) begin
            if (k < ref1.size()) begin
                check($sformatf("s4_row%0d", k), obs1[k].row, ref1[k].row);
                check($sformatf("s4_col%0d", k), obs1[k].col, ref1[k].col);
                check($sformatf("s4_win%0d", k), obs1[k].win, ref1[k].win);
                check($sformatf("s4_last%0d", k), obs1[k].last, ref1[k].last);
            end
        end
        check("s4_count2", obs2.size(), 9);

        // Scenario 5: two frames back-to-back.
        obs1.delete(); obs2.delete();
        send_frame(0, 0);
        send_frame(100, 0);
        drain();
        check("s5_count", obs1.size(), 50);
        if (obs1.size() == 50) begin
            check("s5_f1_last", obs1[24].last, 1);
            o = obs1[25];
            check("s5_f2_row", o.row, 0);
            check("s5_f2_col", o.col, 0);
            check("s5_f2_last", o.last, 0);
            for (int e = 0; e < 9; e++)
                check($sformatf("s5_f2_e%0d", e), o.win[e*WB +: WB], 100 + first_exp[e]);
            o = obs1[49];
            check("s5_end_last", o.last, 1);
            check("s5_end_e22", o.win[8*WB +: WB], 148);
        end
        check("s5_count2", obs2.size(), 18);

        // Scenario 6: reset after 20 pixels, then a fresh frame.
        for (int i = 0; i < 20; i++) send(WB'(200 + i), 0);
        nreset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("s6_rst_valid1", out_valid1, 0);
            check("s6_rst_valid2", out_valid2, 0);
            @(posedge clock); #1;
        end
        nreset = 1'b1;
        obs1.delete(); obs2.delete();
        send_frame(50, 0);
        drain();
        check("s6_count", obs1.size(), 25);
        foreach (obs1[k]) begin
            check($sformatf("s6_row%0d", k), obs1[k].row, k / 5);
            check($sformatf("s6_col%0d", k), obs1[k].col, k % 5);
        end
        if (obs1.size() == 25) begin
            o = obs1[0];
            check("s6_first_e00", o.win[0 +: WB], 50);
            check("s6_first_e22", o.win[8*WB +: WB], 66);
        end
        check("s6_count2", obs2.size(), 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
